// File: rtl/gb_cart_pkg.sv
// gb_cart_pkg: shared definitions for the Game Boy cartridge bus master.
//   - cartOp_t    : command opcodes on cmd_op
//   - cartState_t : bus-cycle sequencer states
//   - ROM_BANK_REG / ROM_BANKN_BASE / CS_REGION_BASE : cartridge memory map anchors
//   - csHit()     : decodes whether an address falls in the /CS (external RAM and up) region
package gb_cart_pkg;

    typedef enum logic [1:0] {
        OP_READ        = 2'b00,
        OP_WRITE       = 2'b01,
        OP_LINEAR_READ = 2'b10,
        OP_RESERVED    = 2'b11
    } cartOp_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } cartState_t;

    localparam logic [15:0] ROM_BANK_REG   = 16'h2000;
    localparam logic [15:0] ROM_BANKN_BASE = 16'h4000;
    localparam logic [15:0] CS_REGION_BASE = 16'hA000;

    // /CS is asserted for 0xA000-0xFFFF, i.e. A15..A13 in {101,110,111}.
    function automatic logic csHit(input logic [15:0] addr);
        return (addr[15:13] >= CS_REGION_BASE[15:13]);
    endfunction

endpackage

// File: rtl/gb_phase_timer.sv
// gb_phase_timer: counts system clocks inside a bus phase and phases inside a state.
//   clock, reset   : system clock, synchronous active-high reset
//   clear          : restart counting from clock 0 of phase 0 on the next edge
//   numPhases      : number of phases the current state lasts (1 or 2)
//   phaseEnd       : current clock is the last clock of a phase
//   lastClk        : current clock is the last clock of the last phase of the state
//   phaseIdx       : index of the current phase within the state
module gb_phase_timer #(
    parameter int PHASE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] numPhases,
    output logic       phaseEnd,
    output logic       lastClk,
    output logic [1:0] phaseIdx
);

    localparam logic [7:0] LAST_CYCLE = 8'(PHASE_CYCLES - 1);

    logic [7:0] cycleCnt;

    assign phaseEnd = (cycleCnt == LAST_CYCLE);
    assign lastClk  = phaseEnd && (phaseIdx == (numPhases - 2'd1));

    // Clock-within-phase and phase-within-state counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycleCnt <= 8'd0;
            phaseIdx <= 2'd0;
        end else if (clear) begin
            cycleCnt <= 8'd0;
            phaseIdx <= 2'd0;
        end else if (phaseEnd) begin
            cycleCnt <= 8'd0;
            phaseIdx <= phaseIdx + 2'd1;
        end else begin
            cycleCnt <= cycleCnt + 8'd1;
        end
    end

endmodule

// File: rtl/gb_cart_master.sv
// gb_cart_master: command-driven bus master for a Game Boy cartridge slot.
//   Optional feature macro: GB_LINEAR_READ_EN compiles in LINEAR_READ (op 10),
//   which maps a 21-bit ROM address onto bank-register write + banked read,
//   skipping the bank write when the cached bank already matches.
// Ports:
//   clock, reset                       : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/
//   cmd_addr/cmd_wdata                 : command handshake and payload
//   rsp_valid/rsp_data/rsp_err         : one-cycle completion pulse and result
//   cart_addr, cart_dout/cart_doe/
//   cart_din                           : cartridge address and split data bus
//   cart_rd_n/cart_wr_n/cart_cs_n/
//   cart_phi                           : active-low strobes, /CS and bus clock
// A bus cycle is ADDR (1 phase), STROBE (2 phases), HOLD (1 phase), then DONE.
// All outputs are registered; they are decoded from the next-state values.
module gb_cart_master
    import gb_cart_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [20:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic [15:0] cart_addr,
    output logic [7:0]  cart_dout,
    output logic        cart_doe,
    input  logic [7:0]  cart_din,
    output logic        cart_rd_n,
    output logic        cart_wr_n,
    output logic        cart_cs_n,
    output logic        cart_phi
);

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] ADDR   = ST_ADDR;
    localparam logic [2:0] STROBE = ST_STROBE;
    localparam logic [2:0] HOLD   = ST_HOLD;
    localparam logic [2:0] DONE   = ST_DONE;

    logic [2:0]  state;
    logic        isWrite;
    logic        pending;      // a banked read follows the current bank-register write
    logic [13:0] linAddr;
    logic        errFlag;
    logic        cacheValid;
    logic [6:0]  cacheBank;
    logic [7:0]  readData;

    logic [2:0]  nState;
    logic [15:0] nAddr;
    logic        nIsWrite;
    logic        nPending;
    logic [13:0] nLinAddr;
    logic [7:0]  nWdata;
    logic        nErr;
    logic        nCacheValid;
    logic [6:0]  nCacheBank;

    logic        inBus;
    logic        busNext;
    logic        nextStrobeFirst;
    logic        phaseEnd;
    logic        lastClk;
    logic [1:0]  phaseIdx;
    logic [1:0]  numPhases;

`ifdef GB_LINEAR_READ_EN
    logic [6:0]  linBank;
    assign linBank = cmd_addr[20:14];
`else
    logic        unusedLinear;
    assign unusedLinear = ^{cmd_addr[20:16], cacheBank};
`endif

    assign inBus     = (state == ADDR) || (state == STROBE) || (state == HOLD);
    assign numPhases = (state == STROBE) ? 2'd2 : 2'd1;

    gb_phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (!inBus || lastClk),
        .numPhases(numPhases),
        .phaseEnd (phaseEnd),
        .lastClk  (lastClk),
        .phaseIdx (phaseIdx)
    );

    // Next-state and next-transaction decode.
    always_comb begin
        nState      = state;
        nAddr       = cart_addr;
        nIsWrite    = isWrite;
        nPending    = pending;
        nLinAddr    = linAddr;
        nWdata      = cart_dout;
        nErr        = errFlag;
        nCacheValid = cacheValid;
        nCacheBank  = cacheBank;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    nErr     = 1'b0;
                    nPending = 1'b0;
                    nIsWrite = 1'b0;
                    case (cmd_op)
                        OP_READ: begin
                            nAddr  = cmd_addr[15:0];
                            nState = ADDR;
                        end
                        OP_WRITE: begin
                            nAddr    = cmd_addr[15:0];
                            nIsWrite = 1'b1;
                            nWdata   = cmd_wdata;
                            nState   = ADDR;
                            // Any CPU write into the bank register window makes the cache stale.
                            if (cmd_addr[15:13] == ROM_BANK_REG[15:13]) begin
                                nCacheValid = 1'b0;
                            end else begin
                                nCacheValid = cacheValid;
                            end
                        end
                        OP_LINEAR_READ: begin
`ifdef GB_LINEAR_READ_EN
                            nState = ADDR;
                            if (linBank == 7'd0) begin
                                nAddr = {2'b00, cmd_addr[13:0]};
                            end else if (cacheValid && (linBank == cacheBank)) begin
                                nAddr = {ROM_BANKN_BASE[15:14], cmd_addr[13:0]};
                            end else begin
                                // Select the bank first; the banked read is chained after HOLD.
                                nAddr       = ROM_BANK_REG;
                                nIsWrite    = 1'b1;
                                nWdata      = {1'b0, linBank};
                                nPending    = 1'b1;
                                nLinAddr    = cmd_addr[13:0];
                                nCacheValid = 1'b1;
                                nCacheBank  = linBank;
                            end
`else
                            nState = DONE;
                            nErr   = 1'b1;
`endif
                        end
                        default: begin
                            nState = DONE;
                            nErr   = 1'b1;
                        end
                    endcase
                end else begin
                    nState = IDLE;
                end
            end
            ADDR: begin
                if (lastClk) begin
                    nState = STROBE;
                end else begin
                    nState = ADDR;
                end
            end
            STROBE: begin
                if (lastClk) begin
                    nState = HOLD;
                end else begin
                    nState = STROBE;
                end
            end
            HOLD: begin
                if (lastClk && pending) begin
                    nState   = ADDR;
                    nAddr    = {ROM_BANKN_BASE[15:14], linAddr};
                    nIsWrite = 1'b0;
                    nPending = 1'b0;
                end else if (lastClk) begin
                    nState = DONE;
                end else begin
                    nState = HOLD;
                end
            end
            DONE: begin
                nState = IDLE;
            end
            default: begin
                nState = IDLE;
            end
        endcase
    end

    assign busNext = (nState == ADDR) || (nState == STROBE) || (nState == HOLD);
    // Next clock is still in STROBE's first phase (entering it, or not at its end yet).
    assign nextStrobeFirst = (state != STROBE) || ((phaseIdx == 2'd0) && !phaseEnd);

    // Sequencer state and registered bus/response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            isWrite    <= 1'b0;
            pending    <= 1'b0;
            linAddr    <= 14'd0;
            errFlag    <= 1'b0;
            cacheValid <= 1'b0;
            cacheBank  <= 7'd0;
            readData   <= 8'h00;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_err    <= 1'b0;
            cart_addr  <= 16'h0000;
            cart_dout  <= 8'h00;
            cart_doe   <= 1'b0;
            cart_rd_n  <= 1'b1;
            cart_wr_n  <= 1'b1;
            cart_cs_n  <= 1'b1;
            cart_phi   <= 1'b0;
        end else begin
            state      <= nState;
            isWrite    <= nIsWrite;
            pending    <= nPending;
            linAddr    <= nLinAddr;
            errFlag    <= nErr;
            cacheValid <= nCacheValid;
            cacheBank  <= nCacheBank;
            if ((state == STROBE) && lastClk && !isWrite) begin
                readData <= cart_din;
            end else begin
                readData <= readData;
            end
            cmd_ready <= (nState == IDLE);
            rsp_valid <= (nState == DONE);
            rsp_err   <= (nState == DONE) && nErr;
            if (nState == DONE) begin
                rsp_data <= nErr ? 8'hFF : (nIsWrite ? 8'h00 : readData);
            end else begin
                rsp_data <= 8'h00;
            end
            cart_addr <= nAddr;
            cart_dout <= nWdata;
            cart_doe  <= nIsWrite && busNext;
            cart_rd_n <= !(!nIsWrite && ((nState == ADDR) || (nState == STROBE)));
            cart_wr_n <= !(nIsWrite && (nState == STROBE));
            cart_cs_n <= !(busNext && csHit(nAddr));
            cart_phi  <= (nState == ADDR) || ((nState == STROBE) && nextStrobeFirst);
        end
    end

endmodule

// File: tb/tb_gb_cart_master.sv
// tb_gb_cart_master: self-checking bench for gb_cart_master (PHASE_CYCLES = 4).
// Expected responses are queued when a command is issued and compared when
// rsp_valid appears; a negedge monitor tallies strobe activity per command.
module tb_gb_cart_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [20:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [15:0] cart_addr;
    logic [7:0]  cart_dout;
    logic        cart_doe;
    logic [7:0]  cart_din;
    logic        cart_rd_n;
    logic        cart_wr_n;
    logic        cart_cs_n;
    logic        cart_phi;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } rsp_t;
    rsp_t expQ[$];

    // Monitor state (written only by the monitor process).
    logic        monClr = 1'b0;
    int          wrLow, rdLow, doeCnt, csRdLow, phiCnt, rspCnt;
    logic        prevWr, prevRd;
    logic [23:0] wrLog[$];
    logic [15:0] rdLog[$];

    always #5 clock = ~clock;

    gb_cart_master #(.PHASE_CYCLES(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .cart_addr(cart_addr),
        .cart_dout(cart_dout),
        .cart_doe (cart_doe),
        .cart_din (cart_din),
        .cart_rd_n(cart_rd_n),
        .cart_wr_n(cart_wr_n),
        .cart_cs_n(cart_cs_n),
        .cart_phi (cart_phi)
    );

    always @(negedge clock) begin
        if (monClr) begin
            wrLow = 0; rdLow = 0; doeCnt = 0; csRdLow = 0; phiCnt = 0; rspCnt = 0;
            prevWr = 1'b1; prevRd = 1'b1;
            wrLog.delete(); rdLog.delete();
        end else begin
            if (cart_wr_n === 1'b0) begin
                wrLow++;
                if (prevWr) wrLog.push_back({cart_addr, cart_dout});
            end
            if (cart_rd_n === 1'b0) begin
                rdLow++;
                if (prevRd) rdLog.push_back(cart_addr);
            end
            if (cart_doe === 1'b1) doeCnt++;
            if (cart_rd_n === 1'b0 && cart_cs_n === 1'b0) csRdLow++;
            if (cart_phi === 1'b1) phiCnt++;
            if (rsp_valid === 1'b1) rspCnt++;
            prevWr = cart_wr_n;
            prevRd = cart_rd_n;
        end
    end

    task automatic startMon();
        monClr = 1'b1;
        @(negedge clock);
        #1 monClr = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [20:0] addr,
                         input logic [7:0] wdata, input logic [7:0] expData,
                         input logic expErr);
        rsp_t e;
        startMon();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        e.data = expData;
        e.err  = expErr;
        expQ.push_back(e);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    // Scoreboard collection: wait for rsp_valid, pop the expected entry, compare.
    task automatic collect(output int lat);
        rsp_t e;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within 200 cycles");
        end else if (expQ.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: data %h err %b with empty scoreboard", rsp_data, rsp_err);
        end else begin
            e = expQ.pop_front();
            if (rsp_data !== e.data || rsp_err !== e.err) begin
                errors++;
                $display("FAIL rsp_payload: got data %h err %b want data %h err %b",
                         rsp_data, rsp_err, e.data, e.err);
            end
        end
        repeat (3) @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 21'd0; cmd_wdata = 8'h00;
        cart_din = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: ready %b valid %b data %h err %b want 1 0 00 0",
                     cmd_ready, rsp_valid, rsp_data, rsp_err);
        end
        checks++;
        if (cart_addr !== 16'h0000 || cart_dout !== 8'h00 || cart_doe !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: addr %h dout %h doe %b want 0000 00 0", cart_addr, cart_dout, cart_doe);
        end
        checks++;
        if (cart_rd_n !== 1'b1 || cart_wr_n !== 1'b1 || cart_cs_n !== 1'b1 || cart_phi !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: rd %b wr %b cs %b phi %b want 1 1 1 0",
                     cart_rd_n, cart_wr_n, cart_cs_n, cart_phi);
        end
    endtask

    task automatic test_write();
        int lat;
        issue(2'b01, 21'h02000, 8'h05, 8'h00, 1'b0);
        collect(lat);
        checks++;
        if (lat != 17) begin errors++; $display("FAIL write_latency: got %0d want 17", lat); end
        checks++;
        if (wrLow != 8) begin errors++; $display("FAIL write_wr_low: got %0d want 8", wrLow); end
        checks++;
        if (doeCnt != 16) begin errors++; $display("FAIL write_doe: got %0d want 16", doeCnt); end
        checks++;
        if (rdLow != 0 || phiCnt != 8) begin
            errors++; $display("FAIL write_rd_phi: rd %0d phi %0d want 0 8", rdLow, phiCnt);
        end
        checks++;
        if (wrLog.size() != 1 || wrLog[0] !== {16'h2000, 8'h05}) begin
            errors++; $display("FAIL write_bus: %0d writes first %h want 1 at 200005", wrLog.size(),
                               (wrLog.size() > 0) ? wrLog[0] : 24'h0);
        end
        checks++;
        if (cart_cs_n !== 1'b1 || cart_doe !== 1'b0 || cart_addr !== 16'h2000) begin
            errors++; $display("FAIL write_idle: cs %b doe %b addr %h want 1 0 2000",
                               cart_cs_n, cart_doe, cart_addr);
        end
    endtask

    task automatic test_read();
        int lat;
        cart_din = 8'h5A;
        issue(2'b00, 21'h0A123, 8'h00, 8'h5A, 1'b0);
        collect(lat);
        checks++;
        if (lat != 17) begin errors++; $display("FAIL read_latency: got %0d want 17", lat); end
        checks++;
        if (csRdLow != 12 || rdLow != 12) begin
            errors++; $display("FAIL read_cs_rd: cs&rd %0d rd %0d want 12 12", csRdLow, rdLow);
        end
        checks++;
        if (wrLow != 0 || doeCnt != 0 || rdLog.size() != 1 || rdLog[0] !== 16'hA123) begin
            errors++; $display("FAIL read_bus: wr %0d doe %0d reads %0d want 0 0 1 at A123",
                               wrLow, doeCnt, rdLog.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [3] = '{16'hC000, 16'h8000, 16'hFFFF};
        logic [7:0]  dins  [3] = '{8'h11, 8'hE7, 8'h00};
        int lat;
        for (int i = 0; i < 3; i++) begin
            cart_din = dins[i];
            issue(2'b00, {5'd0, addrs[i]}, 8'h00, dins[i], 1'b0);
            collect(lat);
            checks++;
            if (csRdLow != ((addrs[i] >= 16'hA000) ? 12 : 0)) begin
                errors++; $display("FAIL b2b_cs: addr %h cs&rd %0d", addrs[i], csRdLow);
            end
        end
    endtask

    task automatic test_reserved();
        int lat;
        issue(2'b11, 21'h0A000, 8'h00, 8'hFF, 1'b1);
        collect(lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL reserved_latency: got %0d want 1", lat); end
        checks++;
        if (wrLow != 0 || rdLow != 0 || doeCnt != 0 || phiCnt != 0) begin
            errors++; $display("FAIL reserved_bus: wr %0d rd %0d doe %0d phi %0d want 0",
                               wrLow, rdLow, doeCnt, phiCnt);
        end
    endtask

`ifdef GB_LINEAR_READ_EN
    task automatic linCheck(input logic [20:0] addr, input bit expWrite, input logic [15:0] expRd,
                            input logic [7:0] din, input string tag);
        int lat;
        cart_din = din;
        issue(2'b10, addr, 8'h00, din, 1'b0);
        collect(lat);
        checks++;
        if (lat != (expWrite ? 33 : 17) || rspCnt != 1) begin
            errors++; $display("FAIL %s_timing: lat %0d rsp %0d want %0d 1", tag, lat, rspCnt,
                               expWrite ? 33 : 17);
        end
        checks++;
        if (wrLog.size() != (expWrite ? 1 : 0) ||
            (expWrite && wrLog[0] !== {16'h2000, 1'b0, addr[20:14]})) begin
            errors++; $display("FAIL %s_bankwrite: writes %0d want %0d", tag, wrLog.size(),
                               expWrite ? 1 : 0);
        end
        checks++;
        if (rdLog.size() != 1 || rdLog[0] !== expRd) begin
            errors++; $display("FAIL %s_read: reads %0d first %h want 1 at %h", tag, rdLog.size(),
                               (rdLog.size() > 0) ? rdLog[0] : 16'h0, expRd);
        end
    endtask

    task automatic test_linear();
        linCheck(21'h1C000, 1'b1, 16'h4000, 8'h3C, "lin_miss");
        linCheck(21'h1C000, 1'b0, 16'h4000, 8'hC3, "lin_hit");
        linCheck(21'h01234, 1'b0, 16'h1234, 8'h99, "lin_bank0");
        issue(2'b01, 21'h03FFF, 8'h01, 8'h00, 1'b0);
        begin int lat; collect(lat); end
        linCheck(21'h1C000, 1'b1, 16'h4000, 8'h42, "lin_inval");
    endtask
`else
    task automatic test_linear();
        int lat;
        issue(2'b10, 21'h1C000, 8'h00, 8'hFF, 1'b1);
        collect(lat);
        checks++;
        if (lat != 1 || wrLow != 0 || rdLow != 0 || doeCnt != 0) begin
            errors++; $display("FAIL lin_disabled: lat %0d wr %0d rd %0d doe %0d want 1 0 0 0",
                               lat, wrLow, rdLow, doeCnt);
        end
    endtask
`endif

    task automatic test_reset_mid();
        cart_din = 8'h77;
        issue(2'b00, 21'h0A123, 8'h00, 8'h77, 1'b0);
        repeat (6) @(negedge clock);
        checks++;
        if (cart_rd_n !== 1'b0) begin errors++; $display("FAIL mid_strobe_rd: got %b want 0", cart_rd_n); end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (cart_rd_n !== 1'b1 || cart_wr_n !== 1'b1 || cart_cs_n !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_strobes: rd %b wr %b cs %b ready %b want 1 1 1 1",
                               cart_rd_n, cart_wr_n, cart_cs_n, cmd_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        expQ.delete();
        repeat (30) @(negedge clock);
        #1;
        checks++;
        if (rspCnt != 0) begin errors++; $display("FAIL mid_reset_rsp: got %0d pulses want 0", rspCnt); end
`ifdef GB_LINEAR_READ_EN
        linCheck(21'h1C000, 1'b1, 16'h4000, 8'h5E, "lin_after_reset");
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reserved();
        test_linear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gb_cart_master.md
GB_CART_MASTER -- requirements
Module: gb_cart_master

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 4, system clocks per bus phase (legal 1..255).
REQ-002 clock  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-006 cmd_op  in  2  00 READ, 01 WRITE, 10 LINEAR_READ, 11 reserved.
REQ-007 cmd_addr  in  21  [15:0] CPU address for READ/WRITE; full 21-bit linear ROM address for LINEAR_READ.
REQ-008 cmd_wdata  in  8  write data.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_data  out  8  read data; 0x00 for WRITE; 0xFF on error.
REQ-011 rsp_err  out  1  valid with rsp_valid; 1 for unsupported op.
REQ-012 cart_addr  out  16  cartridge A15-A0.
REQ-013 cart_dout / cart_doe / cart_din  out 8 / out 1 / in 8  cartridge data bus, split tristate.
REQ-014 cart_rd_n, cart_wr_n, cart_cs_n, cart_phi  out  1 each  active-low strobes, /CS, bus clock.

Function
REQ-015 States: IDLE, ADDR (1 phase), STROBE (2 phases), HOLD (1 phase), DONE (1 cycle); a phase is PHASE_CYCLES clocks.
REQ-016 cmd_ready SHALL be 1 only in IDLE; accept at edge N -> ADDR from cycle N+1, DONE in cycle N+1+4*PHASE_CYCLES, then IDLE.
REQ-017 cart_addr and cart_cs_n SHALL be latched at accept and held stable through HOLD; cart_cs_n = 0 iff addr[15:13] in {101,110,111}.
REQ-018 READ: cart_rd_n = 0 in ADDR and STROBE; cart_din registered on the last clock of STROBE; rsp_data returns that value in DONE.
REQ-019 WRITE: cart_doe = 1 from ADDR through HOLD; cart_wr_n = 0 only during STROBE; rsp_data = 0x00.
REQ-020 cart_phi SHALL be 1 in ADDR and the first STROBE phase, 0 otherwise (including IDLE).
REQ-021 Outside a bus cycle: rd_n = wr_n = cs_n = 1, doe = 0, cart_addr held at last value.
REQ-022 Reserved op (and LINEAR_READ when compiled out): no bus activity; DONE one cycle after accept; rsp_err = 1, rsp_data = 0xFF.
REQ-023 A plain WRITE with addr[15:13] = 001 SHALL invalidate the bank cache.

Reset
REQ-024 Reset SHALL force IDLE on the next edge, abort any cycle without rsp_valid, and drive: cmd_ready 1, rsp_valid 0, rsp_data 0x00, rsp_err 0, cart_addr 0x0000, cart_dout 0x00, cart_doe 0, strobes 1, cart_phi 0, bank cache invalid.

Configuration
REQ-025 Macro GB_LINEAR_READ_EN SHALL compile in LINEAR_READ; without it, op 10 behaves per REQ-022.
REQ-026 LINEAR_READ, bank = cmd_addr[20:14]: bank 0 -> one READ at {2'b00, addr[13:0]}; bank equal to valid cache -> one READ at {2'b01, addr[13:0]}; else WRITE bank to 0x2000, update cache, then READ at {2'b01, addr[13:0]}.
REQ-027 The two-cycle LINEAR_READ SHALL return to ADDR directly after the write's HOLD (no DONE, cmd_ready stays 0) and produce exactly one rsp_valid.

Structure
REQ-028 Package gb_cart_pkg SHALL hold the op and state enums and constants ROM_BANK_REG 0x2000, ROM_BANKN_BASE 0x4000, CS_REGION_BASE 0xA000.
REQ-029 Sub-module gb_phase_timer SHALL count clocks within a phase and flag phase end and last clock.

Verification
REQ-030 PHASE_CYCLES=4, WRITE 0x2000<-0x05: wr_n low exactly 8 clocks, doe 16 clocks, cs_n 1, rsp_valid in cycle N+17, rsp_err 0.
REQ-031 READ 0xA123, cart_din 0x5A: cs_n 0 and rd_n 0 for 12 clocks, rsp_data 0x5A.
REQ-032 LINEAR_READ 0x1C000 twice: first issues write 0x07 to 0x2000 then read 0x4000; second issues only read 0x4000; one rsp_valid each.
REQ-033 LINEAR_READ 0x01234: single read at 0x1234, no write; cmd_op 11: rsp_err 1, rsp_data 0xFF, no strobe.
REQ-034 Reset asserted mid-STROBE: strobes high on next edge, no rsp_valid, following LINEAR_READ with bank 7 re-issues the bank write.
